tri_setup: RTL and testbench

- Sits directly downstream of the pre-processing/shading stage; consumes one shaded triangle per valid/ready handshake.
- Maps viewport-space vertex positions to signed screen-pixel coordinates.
- Computes the twice-signed area and a screen-clamped bounding box, then normalises winding.
- Drops degenerate, back-facing (optional) and fully off-screen triangles before they reach the rasterizer.

---
 rtl/tri_setup_pkg.sv | 30 +++
 rtl/vp_to_pixel.sv | 34 +++
 rtl/tri_setup.sv | 172 +++++++++++++++++
 tb/tb_tri_setup.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_setup_pkg.sv
// Shared graphics types for triangle setup: screen constants, pixel type,
// bounding-box struct and the setup FSM state encoding.
package tri_setup_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 180;
  localparam int PIX_WIDTH  = 12;
  localparam int BBOX_XW    = $clog2(SCREEN_W);
  localparam int BBOX_YW    = $clog2(SCREEN_H);
  localparam int AREA_WIDTH = 2*PIX_WIDTH + 2;

  typedef logic signed [PIX_WIDTH-1:0] pix_t;

  typedef struct packed {
    logic [BBOX_XW-1:0] x_min;
    logic [BBOX_XW-1:0] x_max;
    logic [BBOX_YW-1:0] y_min;
    logic [BBOX_YW-1:0] y_max;
  } bbox_t;

  typedef enum logic [2:0] {IDLE, SCALE, AREA, DECIDE, HOLD} state_t;

  // Clamp a signed pixel coordinate into [0, hi].
  function automatic pix_t clamp_pix(pix_t v, pix_t hi);
    if (v[PIX_WIDTH-1]) return '0;
    if (v > hi)         return hi;
    return v;
  endfunction

endpackage

// File: rtl/vp_to_pixel.sv
// Combinational viewport-to-pixel mapping of one coordinate:
// offset +/- ((pos * scale) >>> frac_bits), saturated to the pixel range.
module vp_to_pixel
  import tri_setup_pkg::*;
#(
  parameter int POS_WIDTH = 18,
  parameter int FRAC_BITS = 14,
  parameter int SCALE     = 32,
  parameter int OFFSET    = 160,
  parameter bit NEGATE    = 1'b0
) (
  input  logic signed [POS_WIDTH-1:0] pos,
  output pix_t                        pix
);

  localparam int PROD_W  = POS_WIDTH + 33;
  localparam int PIX_MAX = 2**(PIX_WIDTH-1) - 1;
  localparam int PIX_MIN = -(2**(PIX_WIDTH-1));

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [PROD_W-1:0] wide;

  always_comb begin
    prod    = PROD_W'(pos) * PROD_W'(SCALE);
    shifted = prod >>> FRAC_BITS;
    if (NEGATE) wide = PROD_W'(OFFSET) - shifted;
    else        wide = PROD_W'(OFFSET) + shifted;
    if (wide > PROD_W'(PIX_MAX))      pix = pix_t'(PIX_MAX);
    else if (wide < PROD_W'(PIX_MIN)) pix = pix_t'(PIX_MIN);
    else                              pix = wide[PIX_WIDTH-1:0];
  end

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: viewport-to-pixel mapping, signed area, winding fix-up,
// clamped bounding box and culling of degenerate/back/off-screen triangles.
module tri_setup
  import tri_setup_pkg::*;
#(
  parameter int C_WIDTH                   = 18,
  parameter int VIEWPORT_H_POSITION_WIDTH = 18,
  parameter int VIEWPORT_W_POSITION_WIDTH = 20,
  parameter int FRAC_BITS                 = 14,
  parameter int X_SCALE                   = 32,
  parameter int Y_SCALE                   = 32,
  parameter bit CULL_BACK                 = 1'b0,
  parameter int COLOR_WIDTH               = 16
) (
  input  logic                                       clk_in,
  input  logic                                       rst_n_in,
  input  logic                                       valid_in,
  output logic                                       ready_out,
  input  logic [2:0][VIEWPORT_H_POSITION_WIDTH-1:0]  viewport_x_positions_in,
  input  logic [2:0][VIEWPORT_W_POSITION_WIDTH-1:0]  viewport_y_positions_in,
  input  logic [2:0][C_WIDTH:0]                      z_depth_in,
  input  logic [COLOR_WIDTH-1:0]                     color_in,
  output logic                                       valid_out,
  input  logic                                       ready_in,
  output logic [2:0][PIX_WIDTH-1:0]                  pix_x_out,
  output logic [2:0][PIX_WIDTH-1:0]                  pix_y_out,
  output logic [BBOX_XW-1:0]                         bbox_x_min_out,
  output logic [BBOX_XW-1:0]                         bbox_x_max_out,
  output logic [BBOX_YW-1:0]                         bbox_y_min_out,
  output logic [BBOX_YW-1:0]                         bbox_y_max_out,
  output logic signed [AREA_WIDTH-1:0]               area_out,
  output logic [2:0][C_WIDTH:0]                      z_depth_out,
  output logic [COLOR_WIDTH-1:0]                     color_out,
  output logic [15:0]                                drop_count_out
);

  // One bit wider than area_out so the raw difference of products never wraps.
  localparam int AW = 2*PIX_WIDTH + 3;

  state_t                                      state;
  logic [2:0][VIEWPORT_H_POSITION_WIDTH-1:0]   x_q;
  logic [2:0][VIEWPORT_W_POSITION_WIDTH-1:0]   y_q;
  logic [2:0][C_WIDTH:0]                       z_q;
  logic [COLOR_WIDTH-1:0]                      color_q;
  pix_t                                        px_c [3];
  pix_t                                        py_c [3];
  pix_t                                        px_q [3];
  pix_t                                        py_q [3];
  logic signed [AW-1:0]                        area_c, area_q;

  pix_t  x_min, x_max, y_min, y_max;
  bbox_t bbox_c;
  logic  swap, drop, off_screen;

  for (genvar i = 0; i < 3; i++) begin : g_vtx
    vp_to_pixel #(
      .POS_WIDTH(VIEWPORT_H_POSITION_WIDTH), .FRAC_BITS(FRAC_BITS),
      .SCALE(X_SCALE), .OFFSET(SCREEN_W/2), .NEGATE(1'b0)
    ) u_x (.pos(x_q[i]), .pix(px_c[i]));
    vp_to_pixel #(
      .POS_WIDTH(VIEWPORT_W_POSITION_WIDTH), .FRAC_BITS(FRAC_BITS),
      .SCALE(Y_SCALE), .OFFSET(SCREEN_H/2), .NEGATE(1'b1)
    ) u_y (.pos(y_q[i]), .pix(py_c[i]));
  end

  always_comb begin
    area_c = (AW'(px_q[1]) - AW'(px_q[0])) * (AW'(py_q[2]) - AW'(py_q[0]))
           - (AW'(px_q[2]) - AW'(px_q[0])) * (AW'(py_q[1]) - AW'(py_q[0]));
  end

  // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    x_min = px_q[0];
    x_max = px_q[0];
    y_min = py_q[0];
    y_max = py_q[0];
    for (int i = 1; i < 3; i++) begin
      if (px_q[i] < x_min) x_min = px_q[i];
      if (px_q[i] > x_max) x_max = px_q[i];
      if (py_q[i] < y_min) y_min = py_q[i];
      if (py_q[i] > y_max) y_max = py_q[i];
    end
    off_screen = x_max[PIX_WIDTH-1] || (x_min > pix_t'(SCREEN_W-1))
              || y_max[PIX_WIDTH-1] || (y_min > pix_t'(SCREEN_H-1));
    swap = area_q[AW-1];
    drop = (area_q == '0) || (swap && CULL_BACK) || off_screen;
    bbox_c.x_min = BBOX_XW'(clamp_pix(x_min, pix_t'(SCREEN_W-1)));
    bbox_c.x_max = BBOX_XW'(clamp_pix(x_max, pix_t'(SCREEN_W-1)));
    bbox_c.y_min = BBOX_YW'(clamp_pix(y_min, pix_t'(SCREEN_H-1)));
    bbox_c.y_max = BBOX_YW'(clamp_pix(y_max, pix_t'(SCREEN_H-1)));
  end

  // NOTE: pipeline data registers are not reset; the FSM guarantees they are
  // written before use, and reset only needs to reach control and outputs.
  always_ff @(posedge clk_in) begin
    if (state == IDLE && valid_in && ready_out) begin
      x_q     <= viewport_x_positions_in;
      y_q     <= viewport_y_positions_in;
      z_q     <= z_depth_in;
      color_q <= color_in;
    end
    if (state == SCALE) begin
      px_q <= px_c;
      py_q <= py_c;
    end
    if (state == AREA) area_q <= area_c;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      ready_out      <= 1'b1;
      valid_out      <= 1'b0;
      drop_count_out <= '0;
      pix_x_out      <= '0;
      pix_y_out      <= '0;
      bbox_x_min_out <= '0;
      bbox_x_max_out <= '0;
      bbox_y_min_out <= '0;
      bbox_y_max_out <= '0;
      area_out       <= '0;
      z_depth_out    <= '0;
      color_out      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            ready_out <= 1'b0;
            state     <= SCALE;
          end
        end
        SCALE: state <= AREA;
        AREA:  state <= DECIDE;
        DECIDE: begin
          if (drop) begin
            if (drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
            ready_out <= 1'b1;
            state     <= IDLE;
          end else begin
            pix_x_out[0]   <= px_q[0];
            pix_y_out[0]   <= py_q[0];
            z_depth_out[0] <= z_q[0];
            pix_x_out[1]   <= swap ? px_q[2] : px_q[1];
            pix_y_out[1]   <= swap ? py_q[2] : py_q[1];
            z_depth_out[1] <= swap ? z_q[2]  : z_q[1];
            pix_x_out[2]   <= swap ? px_q[1] : px_q[2];
            pix_y_out[2]   <= swap ? py_q[1] : py_q[2];
            z_depth_out[2] <= swap ? z_q[1]  : z_q[2];
            area_out       <= AREA_WIDTH'(swap ? -area_q : area_q);
            bbox_x_min_out <= bbox_c.x_min;
            bbox_x_max_out <= bbox_c.x_max;
            bbox_y_min_out <= bbox_c.y_min;
            bbox_y_max_out <= bbox_c.y_max;
            color_out      <= color_q;
            valid_out      <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_setup.sv
// Scoreboard bench for tri_setup: directed triangles with hand-computed
// expectations, plus a CULL_BACK=1 instance sharing the input buses.
module tb_tri_setup;
  import tri_setup_pkg::*;

  localparam int VHW = 18;
  localparam int VWW = 20;
  localparam int ZW  = 19;
  localparam int CW  = 16;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                          rst_n_in, valid_in, ready_in, valid_c;
  logic [2:0][VHW-1:0]           vx;
  logic [2:0][VWW-1:0]           vy;
  logic [2:0][ZW-1:0]            zin;
  logic [CW-1:0]                 col;

  logic                          ready_out, valid_out;
  logic [2:0][PIX_WIDTH-1:0]     pix_x_out, pix_y_out;
  logic [BBOX_XW-1:0]            bbox_x_min_out, bbox_x_max_out;
  logic [BBOX_YW-1:0]            bbox_y_min_out, bbox_y_max_out;
  logic signed [AREA_WIDTH-1:0]  area_out;
  logic [2:0][ZW-1:0]            z_depth_out;
  logic [CW-1:0]                 color_out;
  logic [15:0]                   drop_count_out;

  logic                          ready_out_c, valid_out_c;
  logic [2:0][PIX_WIDTH-1:0]     pix_x_c, pix_y_c;
  logic [BBOX_XW-1:0]            bxmin_c, bxmax_c;
  logic [BBOX_YW-1:0]            bymin_c, bymax_c;
  logic signed [AREA_WIDTH-1:0]  area_c;
  logic [2:0][ZW-1:0]            z_c;
  logic [CW-1:0]                 color_c;
  logic [15:0]                   drop_count_c;

  tri_setup dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
    .viewport_x_positions_in(vx), .viewport_y_positions_in(vy), .z_depth_in(zin),
    .color_in(col), .valid_out(valid_out), .ready_in(ready_in),
    .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
    .bbox_x_min_out(bbox_x_min_out), .bbox_x_max_out(bbox_x_max_out),
    .bbox_y_min_out(bbox_y_min_out), .bbox_y_max_out(bbox_y_max_out),
    .area_out(area_out), .z_depth_out(z_depth_out), .color_out(color_out),
    .drop_count_out(drop_count_out)
  );

  tri_setup #(.CULL_BACK(1'b1)) dut_c (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_c), .ready_out(ready_out_c),
    .viewport_x_positions_in(vx), .viewport_y_positions_in(vy), .z_depth_in(zin),
    .color_in(col), .valid_out(valid_out_c), .ready_in(1'b1),
    .pix_x_out(pix_x_c), .pix_y_out(pix_y_c),
    .bbox_x_min_out(bxmin_c), .bbox_x_max_out(bxmax_c),
    .bbox_y_min_out(bymin_c), .bbox_y_max_out(bymax_c),
    .area_out(area_c), .z_depth_out(z_c), .color_out(color_c),
    .drop_count_out(drop_count_c)
  );

  typedef struct {
    int px[3];
    int py[3];
    int bb[4];
    int area;
    int z[3];
    int color;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: a transfer happens when valid_out and ready_in are both high.
  exp_t e_mon;
  always @(negedge clk_in) begin
    if (rst_n_in && valid_out && ready_in) begin
      check("sb_has_entry", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          check($sformatf("pix_x[%0d]", i), int'($signed(pix_x_out[i])), e_mon.px[i]);
          check($sformatf("pix_y[%0d]", i), int'($signed(pix_y_out[i])), e_mon.py[i]);
          check($sformatf("z[%0d]", i),     int'(z_depth_out[i]),        e_mon.z[i]);
        end
        check("bbox_x_min", int'(bbox_x_min_out), e_mon.bb[0]);
        check("bbox_x_max", int'(bbox_x_max_out), e_mon.bb[1]);
        check("bbox_y_min", int'(bbox_y_min_out), e_mon.bb[2]);
        check("bbox_y_max", int'(bbox_y_max_out), e_mon.bb[3]);
        check("area",       int'(area_out),       e_mon.area);
        check("color",      int'(color_out),      e_mon.color);
      end
    end
    if (rst_n_in && valid_out_c) check("cull_unexpected_valid", int'(valid_out_c), 0);
  end

  task automatic set_tri(input int x0, input int x1, input int x2,
                         input int y0, input int y1, input int y2,
                         input int z0, input int z1, input int z2, input int c);
    vx[0] = VHW'(x0); vx[1] = VHW'(x1); vx[2] = VHW'(x2);
    vy[0] = VWW'(y0); vy[1] = VWW'(y1); vy[2] = VWW'(y2);
    zin[0] = ZW'(z0); zin[1] = ZW'(z1); zin[2] = ZW'(z2);
    col = CW'(c);
  endtask

  // Returns #1 after the handshake edge.
  task automatic handshake();
    int waited = 0;
    while (!ready_out && waited < 50) begin
      @(posedge clk_in); #1;
      waited++;
    end
    check("ready_wait", int'(ready_out), 1);
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid();
    int waited = 0;
    while (!valid_out && waited < 20) begin
      @(posedge clk_in); #1;
      waited++;
    end
    check("valid_wait", int'(valid_out), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  exp_t e;
  initial begin
    rst_n_in = 1'b0; valid_in = 1'b0; valid_c = 1'b0; ready_in = 1'b1;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready",     int'(ready_out), 1);
    check("rst_valid",     int'(valid_out), 0);
    check("rst_drop",      int'(drop_count_out), 0);
    check("rst_area",      int'(area_out), 0);
    check("rst_bbox_xmax", int'(bbox_x_max_out), 0);
    check("rst_ready_c",   int'(ready_out_c), 1);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Clockwise triangle: v1/v2 swapped, area negated; latency 3.
    set_tri(0, 16384, 0, 0, 0, 16384, 1, 2, 3, 'hABCD);
    e.px = '{160, 160, 192}; e.py = '{90, 58, 90}; e.bb = '{160, 192, 58, 90};
    e.area = 1024; e.z = '{1, 3, 2}; e.color = 'hABCD;
    sb.push_back(e);
    handshake();
    @(posedge clk_in); #1; check("lat_n1", int'(valid_out), 0);
    @(posedge clk_in); #1; check("lat_n2", int'(valid_out), 0);
    @(posedge clk_in); #1; check("lat_n3", int'(valid_out), 1);
    @(posedge clk_in); #1;
    check("t1_valid_clr", int'(valid_out), 0);
    check("t1_ready_set", int'(ready_out), 1);

    // Collinear: zero area.
    set_tri(0, 16384, 32768, 0, 0, 0, 0, 0, 0, 0);
    handshake();
    repeat (4) @(posedge clk_in);
    #1;
    check("degen_drop_count", int'(drop_count_out), 1);
    check("degen_ready",      int'(ready_out), 1);

    // Entirely right of the screen (px = 352).
    set_tri(98304, 98304, 98304, 0, 16384, 0, 0, 0, 0, 0);
    handshake();
    repeat (4) @(posedge clk_in);
    #1;
    check("offscreen_drop_count", int'(drop_count_out), 2);

    // Partly off the left edge: bbox clamps, pixel keeps -32, no swap.
    set_tri(-98304, 0, 0, 0, 16384, 0, 10, 20, 30, 'h1234);
    e.px = '{-32, 160, 160}; e.py = '{90, 58, 90}; e.bb = '{0, 160, 58, 90};
    e.area = 6144; e.z = '{10, 20, 30}; e.color = 'h1234;
    sb.push_back(e);
    handshake();
    wait_valid();
    @(posedge clk_in); #1;
    check("t4_valid_clr", int'(valid_out), 0);

    // Back-pressure: held outputs, busy input ignored.
    ready_in = 1'b0;
    set_tri(0, 0, 16384, 0, 16384, 0, 5, 6, 7, 'h0F0F);
    e.px = '{160, 160, 192}; e.py = '{90, 58, 90}; e.bb = '{160, 192, 58, 90};
    e.area = 1024; e.z = '{5, 6, 7}; e.color = 'h0F0F;
    sb.push_back(e);
    handshake();
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        set_tri(0, 16384, 0, 0, 0, 16384, 1, 2, 3, 'hABCD);
        valid_in = 1'b1;
      end
      @(posedge clk_in); #1;
      check($sformatf("hold_valid_%0d", k), int'(valid_out), 1);
      check($sformatf("hold_ready_%0d", k), int'(ready_out), 0);
      check($sformatf("hold_area_%0d", k),  int'(area_out), 1024);
      check($sformatf("hold_z2_%0d", k),    int'(z_depth_out[2]), 7);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    check("hold_one_transfer", int'(valid_out), 0);
    check("hold_ready_back",   int'(ready_out), 1);
    e.px = '{160, 160, 192}; e.py = '{90, 58, 90}; e.bb = '{160, 192, 58, 90};
    e.area = 1024; e.z = '{1, 3, 2}; e.color = 'hABCD;
    sb.push_back(e);
    handshake();
    wait_valid();
    @(posedge clk_in); #1;

    // CULL_BACK=1 drops the clockwise triangle.
    set_tri(0, 16384, 0, 0, 0, 16384, 1, 2, 3, 'hABCD);
    valid_c = 1'b1;
    @(posedge clk_in); #1;
    valid_c = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    check("cull_drop_count", int'(drop_count_c), 1);
    check("cull_ready",      int'(ready_out_c), 1);

    // Reset while in AREA aborts the triangle.
    handshake();
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    @(posedge clk_in); #1;
    check("midrst_valid",   int'(valid_out), 0);
    check("midrst_ready",   int'(ready_out), 1);
    check("midrst_drop",    int'(drop_count_out), 0);
    check("midrst_drop_c",  int'(drop_count_c), 0);
    check("midrst_area",    int'(area_out), 0);
    check("midrst_pix_x1",  int'(pix_x_out[1]), 0);
    rst_n_in = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    check("postrst_valid", int'(valid_out), 0);
    check("postrst_drop",  int'(drop_count_out), 0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
